pe_idx_loader: RTL and testbench

- Upstream sequencer for the PE address-generation unit.
- Accepts one PE instruction over a valid/ready port and streams that instruction's index words into the write side of the AGU's ping-pong index buffer.
- Waits until the AGU is idle, flips the ping-pong buffer, then issues a one-cycle start with the latched configuration.
- Loading of instruction N+1 overlaps AGU execution of instruction N.

---
 rtl/pe_idx_loader_if.sv | 43 ++++
 rtl/pe_idx_loader.sv | 99 +++++++++
 tb/tb_pe_idx_loader.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pe_idx_loader_if.sv
// pe_idx_loader_if: instruction port, index stream, index-buffer write side and AGU control/config
interface pe_idx_loader_if #(
    parameter int IDX_W      = 8,
    parameter int IDX_ADDR_W = 8
);
    logic                  ins_valid;
    logic                  ins_ready;
    logic [2:0]            ins_mode;
    logic [7:0]            ins_idx_cnt;
    logic [7:0]            ins_trip_cnt;
    logic                  ins_is_new;
    logic [3:0]            ins_pad_code;
    logic                  ins_cut_y;
    logic [2*IDX_W-1:0]    idx_in_data;
    logic                  idx_in_valid;
    logic                  idx_in_ready;
    logic [2*IDX_W-1:0]    idx_wr_data;
    logic [IDX_ADDR_W-1:0] idx_wr_addr;
    logic                  idx_wr_en;
    logic                  switch_idx_buf;
    logic                  agu_start;
    logic                  agu_done;
    logic [2:0]            mode;
    logic [7:0]            idx_cnt;
    logic [7:0]            trip_cnt;
    logic                  is_new;
    logic [3:0]            pad_code;
    logic                  cut_y;
    logic                  busy;

    modport master (
        output ins_valid, ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new, ins_pad_code, ins_cut_y,
        output idx_in_data, idx_in_valid, agu_done,
        input  ins_ready, idx_in_ready, idx_wr_data, idx_wr_addr, idx_wr_en,
        input  switch_idx_buf, agu_start, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, busy
    );
    modport slave (
        input  ins_valid, ins_mode, ins_idx_cnt, ins_trip_cnt, ins_is_new, ins_pad_code, ins_cut_y,
        input  idx_in_data, idx_in_valid, agu_done,
        output ins_ready, idx_in_ready, idx_wr_data, idx_wr_addr, idx_wr_en,
        output switch_idx_buf, agu_start, mode, idx_cnt, trip_cnt, is_new, pad_code, cut_y, busy
    );
endinterface

// File: rtl/pe_idx_loader.sv
// pe_idx_loader: loads one instruction's index words into the AGU ping-pong buffer,
// then flips the buffer and starts the AGU once it is idle.
module pe_idx_loader #(
    parameter int IDX_W      = 8,
    parameter int IDX_DEPTH  = 256,
    parameter int IDX_ADDR_W = $clog2(IDX_DEPTH)
) (
    input logic             clk,
    input logic             rst,
    pe_idx_loader_if.slave  io
);
    typedef enum logic [2:0] {IDLE, LOAD, WAIT, SWITCH, START} state_t;
    state_t state, state_nx;
    logic [7:0]            cnt;
    logic [2:0]            p_mode, c_mode;
    logic [7:0]            p_idx_cnt, c_idx_cnt, p_trip_cnt, c_trip_cnt;
    logic                  p_is_new, c_is_new, p_cut_y, c_cut_y;
    logic [3:0]            p_pad_code, c_pad_code;
    logic [2*IDX_W-1:0]    wr_data;
    logic [IDX_ADDR_W-1:0] wr_addr;
    logic                  wr_en;
    logic                  ins_hs, idx_hs;

    assign ins_hs = io.ins_valid && state == IDLE;
    assign idx_hs = io.idx_in_valid && state == LOAD;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (ins_hs) state_nx = io.ins_idx_cnt != 8'd0 ? LOAD : WAIT;
            LOAD:    if (idx_hs && cnt + 8'd1 == p_idx_cnt) state_nx = WAIT;
            WAIT:    if (io.agu_done) state_nx = SWITCH;
            SWITCH:  state_nx = START;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_en      <= 1'b0;
            wr_data    <= '0;
            wr_addr    <= '0;
            p_mode     <= '0;
            p_idx_cnt  <= '0;
            p_trip_cnt <= '0;
            p_is_new   <= 1'b0;
            p_pad_code <= '0;
            p_cut_y    <= 1'b0;
            c_mode     <= '0;
            c_idx_cnt  <= '0;
            c_trip_cnt <= '0;
            c_is_new   <= 1'b0;
            c_pad_code <= '0;
            c_cut_y    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == START ? 8'd0 : cnt + 8'(idx_hs);
            wr_en <= idx_hs;
            if (idx_hs) begin
                wr_data <= io.idx_in_data;
                wr_addr <= IDX_ADDR_W'(cnt);
            end
            if (ins_hs) begin
                p_mode     <= io.ins_mode;
                p_idx_cnt  <= io.ins_idx_cnt;
                p_trip_cnt <= io.ins_trip_cnt;
                p_is_new   <= io.ins_is_new;
                p_pad_code <= io.ins_pad_code;
                p_cut_y    <= io.ins_cut_y;
            end
            // config lands on the SWITCH cycle so it is stable before and during START
            if (state == WAIT && io.agu_done) begin
                c_mode     <= p_mode;
                c_idx_cnt  <= p_idx_cnt;
                c_trip_cnt <= p_trip_cnt;
                c_is_new   <= p_is_new;
                c_pad_code <= p_pad_code;
                c_cut_y    <= p_cut_y;
            end
        end
    end

    assign io.ins_ready      = state == IDLE;
    assign io.idx_in_ready   = state == LOAD;
    assign io.switch_idx_buf = state == SWITCH;
    assign io.agu_start      = state == START;
    assign io.busy           = state != IDLE;
    assign io.idx_wr_en      = wr_en;
    assign io.idx_wr_data    = wr_data;
    assign io.idx_wr_addr    = wr_addr;
    assign io.mode           = c_mode;
    assign io.idx_cnt        = c_idx_cnt;
    assign io.trip_cnt       = c_trip_cnt;
    assign io.is_new         = c_is_new;
    assign io.pad_code       = c_pad_code;
    assign io.cut_y          = c_cut_y;
endmodule

// File: tb/tb_pe_idx_loader.sv
// tb_pe_idx_loader: directed checks of load/switch/start sequencing, bubbles,
// back-pressure, queued instructions and async reset.
module tb_pe_idx_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail = 0;

    pe_idx_loader_if #(.IDX_W(8), .IDX_ADDR_W(8)) bus ();
    pe_idx_loader #(.IDX_W(8), .IDX_DEPTH(256)) dut (.clk(clk), .rst(rst), .io(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ins(input logic v, input logic [2:0] m, input logic [7:0] ic);
        bus.ins_valid    = v;
        bus.ins_mode     = m;
        bus.ins_idx_cnt  = ic;
        bus.ins_trip_cnt = ic + 8'd3;
        bus.ins_is_new   = m[0];
        bus.ins_pad_code = {1'b1, m};
        bus.ins_cut_y    = m[1];
    endtask

    task automatic word(input logic v, input logic [15:0] d);
        bus.idx_in_valid = v;
        bus.idx_in_data  = d;
    endtask

    task automatic chk_wr(input string tag, input logic en, input logic [15:0] d, input logic [7:0] a);
        chk({tag, "_en"}, 32'(bus.idx_wr_en), 32'(en));
        if (en) begin
            chk({tag, "_data"}, 32'(bus.idx_wr_data), 32'(d));
            chk({tag, "_addr"}, 32'(bus.idx_wr_addr), 32'(a));
        end
    endtask

    initial begin
        set_ins(1'b0, 3'd0, 8'd0);
        word(1'b0, 16'h0);
        bus.agu_done = 1'b1;
        #2;
        chk("rst_wr_en", 32'(bus.idx_wr_en), 0);
        chk("rst_switch", 32'(bus.switch_idx_buf), 0);
        chk("rst_start", 32'(bus.agu_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_mode", 32'(bus.mode), 0);
        chk("rst_idx_cnt", 32'(bus.idx_cnt), 0);
        step();
        step();
        rst = 1'b0;
        step();

        // basic: 4 back-to-back words
        set_ins(1'b1, 3'd5, 8'd4);
        chk("t1_ins_ready", 32'(bus.ins_ready), 1);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        word(1'b1, 16'h0011);
        chk("t1_idx_ready", 32'(bus.idx_in_ready), 1);
        chk("t1_busy", 32'(bus.busy), 1);
        chk("t1_ins_ready_load", 32'(bus.ins_ready), 0);
        step();
        chk_wr("t1_w0", 1'b1, 16'h0011, 8'd0);
        word(1'b1, 16'h0022);
        step();
        chk_wr("t1_w1", 1'b1, 16'h0022, 8'd1);
        word(1'b1, 16'h0033);
        step();
        chk_wr("t1_w2", 1'b1, 16'h0033, 8'd2);
        word(1'b1, 16'h0044);
        step();
        chk_wr("t1_w3", 1'b1, 16'h0044, 8'd3);
        chk("t1_idx_ready_wait", 32'(bus.idx_in_ready), 0);
        chk("t1_no_switch", 32'(bus.switch_idx_buf), 0);
        word(1'b0, 16'h0);
        step();
        chk("t1_switch", 32'(bus.switch_idx_buf), 1);
        chk("t1_sw_no_wr", 32'(bus.idx_wr_en), 0);
        chk("t1_sw_no_start", 32'(bus.agu_start), 0);
        chk("t1_mode", 32'(bus.mode), 5);
        chk("t1_idx_cnt", 32'(bus.idx_cnt), 4);
        step();
        chk("t1_start", 32'(bus.agu_start), 1);
        chk("t1_start_no_sw", 32'(bus.switch_idx_buf), 0);
        chk("t1_trip", 32'(bus.trip_cnt), 7);
        chk("t1_pad", 32'(bus.pad_code), 4'hD);
        chk("t1_is_new", 32'(bus.is_new), 1);
        chk("t1_cut_y", 32'(bus.cut_y), 0);
        step();
        chk("t1_idle_start", 32'(bus.agu_start), 0);
        chk("t1_idle_busy", 32'(bus.busy), 0);
        chk("t1_hold_mode", 32'(bus.mode), 5);

        // zero-length instruction
        set_ins(1'b1, 3'd2, 8'd0);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        chk("t2_no_wr", 32'(bus.idx_wr_en), 0);
        chk("t2_busy", 32'(bus.busy), 1);
        chk("t2_idx_ready", 32'(bus.idx_in_ready), 0);
        chk("t2_no_switch", 32'(bus.switch_idx_buf), 0);
        step();
        chk("t2_switch", 32'(bus.switch_idx_buf), 1);
        chk("t2_sw_no_wr", 32'(bus.idx_wr_en), 0);
        chk("t2_mode", 32'(bus.mode), 2);
        chk("t2_idx_cnt", 32'(bus.idx_cnt), 0);
        step();
        chk("t2_start", 32'(bus.agu_start), 1);
        step();
        chk("t2_idle", 32'(bus.busy), 0);

        // bubbles 1,0,0,1,1 with idx_cnt=3, then AGU back-pressure
        set_ins(1'b1, 3'd1, 8'd3);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        bus.agu_done = 1'b0;
        word(1'b1, 16'h00A1);
        step();
        chk_wr("t3_w0", 1'b1, 16'h00A1, 8'd0);
        word(1'b0, 16'hDEAD);
        step();
        chk("t3_bub0", 32'(bus.idx_wr_en), 0);
        step();
        chk("t3_bub1", 32'(bus.idx_wr_en), 0);
        word(1'b1, 16'h00A2);
        step();
        chk_wr("t3_w1", 1'b1, 16'h00A2, 8'd1);
        word(1'b1, 16'h00A3);
        step();
        chk_wr("t3_w2", 1'b1, 16'h00A3, 8'd2);
        chk("t3_idx_ready_wait", 32'(bus.idx_in_ready), 0);
        word(1'b0, 16'h0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk("t4_hold_no_switch", 32'(bus.switch_idx_buf), 0);
            chk("t4_hold_mode", 32'(bus.mode), 2);
            chk("t4_hold_no_wr", 32'(bus.idx_wr_en), 0);
        end
        chk("t4_busy", 32'(bus.busy), 1);
        bus.agu_done = 1'b1;
        step();
        chk("t4_switch", 32'(bus.switch_idx_buf), 1);
        chk("t4_mode", 32'(bus.mode), 1);
        chk("t4_idx_cnt", 32'(bus.idx_cnt), 3);
        step();
        chk("t4_start", 32'(bus.agu_start), 1);
        step();

        // two queued instructions, ins_valid held high throughout
        set_ins(1'b1, 3'd3, 8'd1);
        step();
        set_ins(1'b1, 3'd4, 8'd2);
        chk("t5_ready_low", 32'(bus.ins_ready), 0);
        word(1'b1, 16'h00B1);
        step();
        chk_wr("t5_x_w0", 1'b1, 16'h00B1, 8'd0);
        chk("t5_ready_low_wait", 32'(bus.ins_ready), 0);
        word(1'b0, 16'h0);
        step();
        chk("t5_x_switch", 32'(bus.switch_idx_buf), 1);
        chk("t5_x_mode", 32'(bus.mode), 3);
        step();
        chk("t5_x_start", 32'(bus.agu_start), 1);
        chk("t5_ready_low_start", 32'(bus.ins_ready), 0);
        bus.agu_done = 1'b0;
        step();
        chk("t5_ready_idle", 32'(bus.ins_ready), 1);
        chk("t5_mode_kept", 32'(bus.mode), 3);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        chk("t5_y_load", 32'(bus.idx_in_ready), 1);
        word(1'b1, 16'h00C1);
        step();
        chk_wr("t5_y_w0", 1'b1, 16'h00C1, 8'd0);
        chk("t5_y_mode_kept", 32'(bus.mode), 3);
        word(1'b1, 16'h00C2);
        step();
        chk_wr("t5_y_w1", 1'b1, 16'h00C2, 8'd1);
        word(1'b0, 16'h0);
        step();
        chk("t5_y_wait", 32'(bus.switch_idx_buf), 0);
        chk("t5_y_mode_wait", 32'(bus.mode), 3);
        bus.agu_done = 1'b1;
        step();
        chk("t5_y_switch", 32'(bus.switch_idx_buf), 1);
        chk("t5_y_mode", 32'(bus.mode), 4);
        chk("t5_y_idx_cnt", 32'(bus.idx_cnt), 2);
        step();
        chk("t5_y_start", 32'(bus.agu_start), 1);
        step();

        // async reset after 2 of 5 words
        set_ins(1'b1, 3'd6, 8'd5);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        word(1'b1, 16'h00D1);
        step();
        word(1'b1, 16'h00D2);
        step();
        chk_wr("t6_w1", 1'b1, 16'h00D2, 8'd1);
        word(1'b0, 16'h0);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_rst_wr_en", 32'(bus.idx_wr_en), 0);
        chk("t6_rst_wr_addr", 32'(bus.idx_wr_addr), 0);
        chk("t6_rst_wr_data", 32'(bus.idx_wr_data), 0);
        chk("t6_rst_busy", 32'(bus.busy), 0);
        chk("t6_rst_mode", 32'(bus.mode), 0);
        chk("t6_rst_idx_ready", 32'(bus.idx_in_ready), 0);
        step();
        rst = 1'b0;
        step();
        set_ins(1'b1, 3'd7, 8'd1);
        step();
        set_ins(1'b0, 3'd0, 8'd0);
        word(1'b1, 16'h00E1);
        step();
        chk_wr("t6_fresh_w0", 1'b1, 16'h00E1, 8'd0);
        word(1'b0, 16'h0);
        step();
        chk("t6_switch", 32'(bus.switch_idx_buf), 1);
        chk("t6_mode", 32'(bus.mode), 7);
        step();
        chk("t6_start", 32'(bus.agu_start), 1);
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
